// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
//
// ID/EX pipeline register for the five-stage MIPS pipeline. It sits directly
// after the register file and registers the operands, register specifiers,
// sign-extended immediate and decoded controls for the EX stage. It also
// provides:
//   - a WB-to-ID write-through bypass, so a value being written back this
//     cycle is captured instead of the stale register file read,
//   - load-use hazard detection, which stalls PC/IF-ID and inserts a bubble,
//   - branch/jump flush, which also inserts a bubble,
//   - a saturating count of inserted bubbles.
//
// Ports:
//   Clk, Rst               clock; asynchronous active-high reset
//   ReadData1/2            register file read data for Rs/Rt
//   Rs, Rt, Rd             ID-stage register specifiers
//   Imm16                  instruction immediate field
//   RegWrite..Branch       decoded ID controls
//   ALUOp                  decoded ALU operation
//   WBRegWrite/WriteReg/   writeback port presented to the register file
//   WBWriteData
//   Flush                  squash the ID instruction (taken branch/jump)
//   Stall                  combinational; PC and IF/ID must hold when 1
//   EX_*                   registered operands, specifiers and controls
//   BubbleCount            bubbles inserted since reset (saturating)
// ---------------------------------------------------------------------------
module id_ex_stage #(
    parameter int ALUOP_W = 4,
    parameter int CNT_W   = 16
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic [31:0]        ReadData1,
    input  logic [31:0]        ReadData2,
    input  logic [4:0]         Rs,
    input  logic [4:0]         Rt,
    input  logic [4:0]         Rd,
    input  logic [15:0]        Imm16,
    input  logic               RegWrite,
    input  logic               MemRead,
    input  logic               MemWrite,
    input  logic               MemToReg,
    input  logic               ALUSrc,
    input  logic               RegDst,
    input  logic               Branch,
    input  logic [ALUOP_W-1:0] ALUOp,
    input  logic               WBRegWrite,
    input  logic [4:0]         WBWriteRegister,
    input  logic [31:0]        WBWriteData,
    input  logic               Flush,
    output logic               Stall,
    output logic [31:0]        EX_ReadData1,
    output logic [31:0]        EX_ReadData2,
    output logic [31:0]        EX_Imm,
    output logic [4:0]         EX_Rs,
    output logic [4:0]         EX_Rt,
    output logic [4:0]         EX_Rd,
    output logic               EX_RegWrite,
    output logic               EX_MemRead,
    output logic               EX_MemWrite,
    output logic               EX_MemToReg,
    output logic               EX_ALUSrc,
    output logic               EX_RegDst,
    output logic               EX_Branch,
    output logic [ALUOP_W-1:0] EX_ALUOp,
    output logic [CNT_W-1:0]   BubbleCount
);

    logic [31:0] byp_a;
    logic [31:0] byp_b;
    logic [31:0] imm_ext;
    logic        bubble;

    // Write-through bypass: register 0 is hardwired to zero and never bypassed.
    always_comb begin
        byp_a = ReadData1;
        byp_b = ReadData2;
        if (WBRegWrite && (WBWriteRegister == Rs) && (Rs != 5'd0)) begin
            byp_a = WBWriteData;
        end
        if (WBRegWrite && (WBWriteRegister == Rt) && (Rt != 5'd0)) begin
            byp_b = WBWriteData;
        end
    end

    assign imm_ext = {{16{Imm16[15]}}, Imm16};

    // Load-use hazard: the load in EX targets a register the ID instruction
    // reads. After one bubble EX_MemRead is 0, so the stall lasts one cycle.
    assign Stall = EX_MemRead && (EX_Rt != 5'd0) && ((EX_Rt == Rs) || (EX_Rt == Rt));

    // Flush and stall both produce one identical bubble, so a simultaneous
    // flush and stall is counted once.
    assign bubble = Flush || Stall;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            EX_ReadData1 <= '0;
            EX_ReadData2 <= '0;
            EX_Imm       <= '0;
            EX_Rs        <= '0;
            EX_Rt        <= '0;
            EX_Rd        <= '0;
            EX_RegWrite  <= 1'b0;
            EX_MemRead   <= 1'b0;
            EX_MemWrite  <= 1'b0;
            EX_MemToReg  <= 1'b0;
            EX_ALUSrc    <= 1'b0;
            EX_RegDst    <= 1'b0;
            EX_Branch    <= 1'b0;
            EX_ALUOp     <= '0;
            BubbleCount  <= '0;
        end else if (bubble) begin
            EX_ReadData1 <= '0;
            EX_ReadData2 <= '0;
            EX_Imm       <= '0;
            EX_Rs        <= '0;
            EX_Rt        <= '0;
            EX_Rd        <= '0;
            EX_RegWrite  <= 1'b0;
            EX_MemRead   <= 1'b0;
            EX_MemWrite  <= 1'b0;
            EX_MemToReg  <= 1'b0;
            EX_ALUSrc    <= 1'b0;
            EX_RegDst    <= 1'b0;
            EX_Branch    <= 1'b0;
            EX_ALUOp     <= '0;
            // Saturate rather than wrap so the counter never under-reports.
            if (BubbleCount != {CNT_W{1'b1}}) begin
                BubbleCount <= BubbleCount + CNT_W'(1);
            end
        end else begin
            EX_ReadData1 <= byp_a;
            EX_ReadData2 <= byp_b;
            EX_Imm       <= imm_ext;
            EX_Rs        <= Rs;
            EX_Rt        <= Rt;
            EX_Rd        <= Rd;
            EX_RegWrite  <= RegWrite;
            EX_MemRead   <= MemRead;
            EX_MemWrite  <= MemWrite;
            EX_MemToReg  <= MemToReg;
            EX_ALUSrc    <= ALUSrc;
            EX_RegDst    <= RegDst;
            EX_Branch    <= Branch;
            EX_ALUOp     <= ALUOp;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_id_ex_stage
//
// Directed testbench for id_ex_stage. A default-width instance and a second
// instance with a 2-bit bubble counter share all stimulus; the second one
// exists only to observe counter saturation.
// ---------------------------------------------------------------------------
module tb_id_ex_stage;

    logic        Clk;
    logic        Rst;
    logic [31:0] ReadData1, ReadData2;
    logic [4:0]  Rs, Rt, Rd;
    logic [15:0] Imm16;
    logic        RegWrite, MemRead, MemWrite, MemToReg, ALUSrc, RegDst, Branch;
    logic [3:0]  ALUOp;
    logic        WBRegWrite;
    logic [4:0]  WBWriteRegister;
    logic [31:0] WBWriteData;
    logic        Flush;

    logic        Stall;
    logic [31:0] EX_ReadData1, EX_ReadData2, EX_Imm;
    logic [4:0]  EX_Rs, EX_Rt, EX_Rd;
    logic        EX_RegWrite, EX_MemRead, EX_MemWrite, EX_MemToReg;
    logic        EX_ALUSrc, EX_RegDst, EX_Branch;
    logic [3:0]  EX_ALUOp;
    logic [15:0] BubbleCount;

    logic        s_Stall;
    logic [31:0] s_ReadData1, s_ReadData2, s_Imm;
    logic [4:0]  s_Rs, s_Rt, s_Rd;
    logic        s_RegWrite, s_MemRead, s_MemWrite, s_MemToReg;
    logic        s_ALUSrc, s_RegDst, s_Branch;
    logic [3:0]  s_ALUOp;
    logic [1:0]  s_BubbleCount;

    int checkCount = 0;
    int failCount  = 0;

    id_ex_stage #(.ALUOP_W(4), .CNT_W(16)) dut (
        .Clk(Clk), .Rst(Rst),
        .ReadData1(ReadData1), .ReadData2(ReadData2),
        .Rs(Rs), .Rt(Rt), .Rd(Rd), .Imm16(Imm16),
        .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite),
        .MemToReg(MemToReg), .ALUSrc(ALUSrc), .RegDst(RegDst), .Branch(Branch),
        .ALUOp(ALUOp),
        .WBRegWrite(WBRegWrite), .WBWriteRegister(WBWriteRegister),
        .WBWriteData(WBWriteData), .Flush(Flush),
        .Stall(Stall),
        .EX_ReadData1(EX_ReadData1), .EX_ReadData2(EX_ReadData2), .EX_Imm(EX_Imm),
        .EX_Rs(EX_Rs), .EX_Rt(EX_Rt), .EX_Rd(EX_Rd),
        .EX_RegWrite(EX_RegWrite), .EX_MemRead(EX_MemRead),
        .EX_MemWrite(EX_MemWrite), .EX_MemToReg(EX_MemToReg),
        .EX_ALUSrc(EX_ALUSrc), .EX_RegDst(EX_RegDst), .EX_Branch(EX_Branch),
        .EX_ALUOp(EX_ALUOp), .BubbleCount(BubbleCount)
    );

    id_ex_stage #(.ALUOP_W(4), .CNT_W(2)) dutSat (
        .Clk(Clk), .Rst(Rst),
        .ReadData1(ReadData1), .ReadData2(ReadData2),
        .Rs(Rs), .Rt(Rt), .Rd(Rd), .Imm16(Imm16),
        .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite),
        .MemToReg(MemToReg), .ALUSrc(ALUSrc), .RegDst(RegDst), .Branch(Branch),
        .ALUOp(ALUOp),
        .WBRegWrite(WBRegWrite), .WBWriteRegister(WBWriteRegister),
        .WBWriteData(WBWriteData), .Flush(Flush),
        .Stall(s_Stall),
        .EX_ReadData1(s_ReadData1), .EX_ReadData2(s_ReadData2), .EX_Imm(s_Imm),
        .EX_Rs(s_Rs), .EX_Rt(s_Rt), .EX_Rd(s_Rd),
        .EX_RegWrite(s_RegWrite), .EX_MemRead(s_MemRead),
        .EX_MemWrite(s_MemWrite), .EX_MemToReg(s_MemToReg),
        .EX_ALUSrc(s_ALUSrc), .EX_RegDst(s_RegDst), .EX_Branch(s_Branch),
        .EX_ALUOp(s_ALUOp), .BubbleCount(s_BubbleCount)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Watchdog so the run always ends even if the sequence stalls somewhere.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drives one ID-stage instruction. ctrl = {RegWrite, MemRead, MemWrite,
    // MemToReg, ALUSrc, RegDst, Branch}.
    task automatic applyStimulus(input logic [4:0] rs, input logic [4:0] rt,
                                 input logic [4:0] rd, input logic [15:0] imm,
                                 input logic [31:0] d1, input logic [31:0] d2,
                                 input logic [6:0] ctrl, input logic [3:0] op);
        Rs = rs; Rt = rt; Rd = rd; Imm16 = imm;
        ReadData1 = d1; ReadData2 = d2;
        {RegWrite, MemRead, MemWrite, MemToReg, ALUSrc, RegDst, Branch} = ctrl;
        ALUOp = op;
    endtask

    // Advance past one rising edge and settle before sampling.
    task automatic stepClock();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        Rst = 1'b1;
        Flush = 1'b0;
        WBRegWrite = 1'b0; WBWriteRegister = 5'd0; WBWriteData = 32'd0;
        applyStimulus(5'd0, 5'd0, 5'd0, 16'h0, 32'h0, 32'h0, 7'b0, 4'h0);
        stepClock();
        stepClock();

        // Reset state
        checkOutput("reset_regwrite", {31'd0, EX_RegWrite}, 32'd0);
        checkOutput("reset_rd1", EX_ReadData1, 32'd0);
        checkOutput("reset_count", {16'd0, BubbleCount}, 32'd0);
        checkOutput("reset_stall", {31'd0, Stall}, 32'd0);
        Rst = 1'b0;

        // Pass-through with negative immediate
        applyStimulus(5'd3, 5'd4, 5'd2, 16'hFFFE, 32'h11, 32'h22, 7'b1000000, 4'h2);
        stepClock();
        checkOutput("pass_rd1", EX_ReadData1, 32'h11);
        checkOutput("pass_rd2", EX_ReadData2, 32'h22);
        checkOutput("pass_imm", EX_Imm, 32'hFFFFFFFE);
        checkOutput("pass_regwrite", {31'd0, EX_RegWrite}, 32'd1);
        checkOutput("pass_rs_rt_rd", {17'd0, EX_Rs, EX_Rt, EX_Rd}, {17'd0, 5'd3, 5'd4, 5'd2});
        checkOutput("pass_aluop", {28'd0, EX_ALUOp}, 32'h2);

        // Bypass on Rs only; positive immediate
        applyStimulus(5'd5, 5'd6, 5'd1, 16'h7FFF, 32'hAAAA, 32'h55, 7'b1000100, 4'h1);
        WBRegWrite = 1'b1; WBWriteRegister = 5'd5; WBWriteData = 32'h1234;
        stepClock();
        checkOutput("byp_rd1", EX_ReadData1, 32'h1234);
        checkOutput("byp_rd2_nobyp", EX_ReadData2, 32'h55);
        checkOutput("byp_imm_pos", EX_Imm, 32'h00007FFF);

        // Register 0 is never bypassed
        Rs = 5'd0; WBWriteRegister = 5'd0;
        stepClock();
        checkOutput("byp_r0", EX_ReadData1, 32'hAAAA);

        // Bypass on Rt only
        Rs = 5'd7; Rt = 5'd9; WBWriteRegister = 5'd9; WBWriteData = 32'hBEEF;
        stepClock();
        checkOutput("byp_rt", EX_ReadData2, 32'hBEEF);
        checkOutput("byp_rt_rd1", EX_ReadData1, 32'hAAAA);
        WBRegWrite = 1'b0;

        // Load-use: load to r8, then a consumer of r8
        applyStimulus(5'd1, 5'd8, 5'd0, 16'h4, 32'h100, 32'h0, 7'b1101100, 4'h0);
        stepClock();
        checkOutput("lu_load_memread", {31'd0, EX_MemRead}, 32'd1);
        applyStimulus(5'd8, 5'd9, 5'd10, 16'h0, 32'h77, 32'h88, 7'b1000010, 4'h3);
        #1;
        checkOutput("lu_stall", {31'd0, Stall}, 32'd1);
        stepClock();
        checkOutput("lu_bubble_regwrite", {31'd0, EX_RegWrite}, 32'd0);
        checkOutput("lu_bubble_rs", {27'd0, EX_Rs}, 32'd0);
        checkOutput("lu_bubble_rd1", EX_ReadData1, 32'd0);
        checkOutput("lu_count", {16'd0, BubbleCount}, 32'd1);
        checkOutput("lu_stall_clear", {31'd0, Stall}, 32'd0);
        stepClock();
        checkOutput("lu_recapture_rs", {27'd0, EX_Rs}, 32'd8);
        checkOutput("lu_recapture_aluop", {28'd0, EX_ALUOp}, 32'h3);
        checkOutput("lu_recapture_regdst", {31'd0, EX_RegDst}, 32'd1);
        checkOutput("lu_count_hold", {16'd0, BubbleCount}, 32'd1);

        // Flush together with stall: one bubble, counter +1
        applyStimulus(5'd2, 5'd7, 5'd0, 16'h8, 32'h0, 32'h0, 7'b1101100, 4'h0);
        stepClock();
        applyStimulus(5'd7, 5'd3, 5'd4, 16'h0, 32'h5, 32'h6, 7'b1000000, 4'h5);
        Flush = 1'b1;
        #1;
        checkOutput("fs_stall", {31'd0, Stall}, 32'd1);
        stepClock();
        checkOutput("fs_count", {16'd0, BubbleCount}, 32'd2);
        checkOutput("fs_regwrite", {31'd0, EX_RegWrite}, 32'd0);

        // Plain flush of an independent instruction
        applyStimulus(5'd3, 5'd4, 5'd5, 16'h1, 32'h9, 32'h9, 7'b1000001, 4'h6);
        stepClock();
        checkOutput("flush_branch", {31'd0, EX_Branch}, 32'd0);
        checkOutput("flush_count", {16'd0, BubbleCount}, 32'd3);
        Flush = 1'b0;

        // Zero register: load to r0 never stalls
        applyStimulus(5'd1, 5'd0, 5'd0, 16'h0, 32'h0, 32'h0, 7'b1101100, 4'h0);
        stepClock();
        applyStimulus(5'd0, 5'd0, 5'd12, 16'h0, 32'h0, 32'h0, 7'b1000010, 4'h7);
        #1;
        checkOutput("r0_stall", {31'd0, Stall}, 32'd0);
        stepClock();
        checkOutput("r0_capture_rd", {27'd0, EX_Rd}, 32'd12);
        checkOutput("r0_count", {16'd0, BubbleCount}, 32'd3);

        // Two more flushes: wide counter reaches 5, 2-bit counter saturates at 3
        Flush = 1'b1;
        stepClock();
        stepClock();
        Flush = 1'b0;
        checkOutput("sat_wide_count", {16'd0, BubbleCount}, 32'd5);
        checkOutput("sat_narrow_count", {30'd0, s_BubbleCount}, 32'd3);

        // Back-to-back loads: dependent load stalls once
        applyStimulus(5'd1, 5'd10, 5'd0, 16'h0, 32'h0, 32'h0, 7'b1101100, 4'h0);
        stepClock();
        applyStimulus(5'd10, 5'd11, 5'd0, 16'h0, 32'h0, 32'h0, 7'b1101100, 4'h0);
        #1;
        checkOutput("b2b_stall", {31'd0, Stall}, 32'd1);
        stepClock();
        checkOutput("b2b_bubble_count", {16'd0, BubbleCount}, 32'd6);
        stepClock();
        checkOutput("b2b_second_load", {26'd0, EX_MemRead, EX_Rt}, {26'd0, 1'b1, 5'd11});

        // Reset asserted mid-stall clears state immediately, no clock edge
        applyStimulus(5'd11, 5'd2, 5'd3, 16'h0, 32'h44, 32'h0, 7'b1000000, 4'h1);
        #1;
        checkOutput("rst_pre_stall", {31'd0, Stall}, 32'd1);
        #1;
        Rst = 1'b1;
        #1;
        checkOutput("rst_async_stall", {31'd0, Stall}, 32'd0);
        checkOutput("rst_async_memread", {31'd0, EX_MemRead}, 32'd0);
        checkOutput("rst_async_rt", {27'd0, EX_Rt}, 32'd0);
        checkOutput("rst_async_count", {16'd0, BubbleCount}, 32'd0);
        checkOutput("rst_async_narrow", {30'd0, s_BubbleCount}, 32'd0);
        #1;
        Rst = 1'b0;
        stepClock();
        checkOutput("rst_resume_rs", {27'd0, EX_Rs}, 32'd11);
        checkOutput("rst_resume_rd1", EX_ReadData1, 32'h44);
        checkOutput("rst_resume_count", {16'd0, BubbleCount}, 32'd0);

        // Reset with EX_RegWrite=1 clears it without an edge
        #2;
        Rst = 1'b1;
        #1;
        checkOutput("rst_mid_regwrite", {31'd0, EX_RegWrite}, 32'd0);
        checkOutput("rst_mid_aluop", {28'd0, EX_ALUOp}, 32'd0);
        Rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
